// File: rtl/flit_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : flit_serializer_if
//  Description : Handshake/link bundle between the router crossbar, the
//                flit serializer and the inter-router link wires.
//  Revision    : 1.0 - initial release
// ============================================================================
interface flit_serializer_if #(
    parameter int FLIT_W     = 24,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              in_valid;
    logic [FLIT_W-1:0] in_flit;
    logic              in_ready;
    logic              channel_busy;
    logic [LANES-1:0]  serial_out;
    logic              tx_active;
    logic              tx_busy;
    logic [CNT_W-1:0]  fifo_count;
    logic              drop_pulse;

    // Crossbar / link side: offers flits and reports link availability
    modport master (
        output in_valid, in_flit, channel_busy,
        input  in_ready, serial_out, tx_active, tx_busy, fifo_count, drop_pulse
    );

    // Serializer side
    modport slave (
        input  in_valid, in_flit, channel_busy,
        output in_ready, serial_out, tx_active, tx_busy, fifo_count, drop_pulse
    );
endinterface
`default_nettype wire

// File: rtl/flit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : flit_serializer
//  Description : Elastic FIFO plus framing serializer: START beat, LSB-first
//                data beats over LANES wires, optional even-parity beat,
//                STOP beat, then GAP forced idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module flit_serializer #(
    parameter int FLIT_W     = 24,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int PARITY_EN  = 0,
    parameter int GAP        = 1
) (
    input  logic              clk,
    input  logic              reset,
    flit_serializer_if.slave  bus
);
    localparam int NB       = FLIT_W / LANES;
    localparam int BEAT_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(NB - 1);
    localparam logic [GAP_W-1:0]  C_GAP_LAST  = GAP_W'(GAP_LAST);
    localparam logic [PTR_W-1:0]  C_PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              in_ready;
    logic              push;
    logic              pop;
    logic [FLIT_W-1:0] head;

    // Ready looks only at the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_ready = (count_q < C_DEPTH);
    assign push     = bus.in_valid & in_ready;
    assign head     = mem_q[rd_ptr_q];

    // FIFO storage write; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_flit;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [FLIT_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              start_ok;
    logic              begin_frame;

    // channel_busy only gates the launch of a frame, never an ongoing one
    assign start_ok = (count_q != '0) & ~bus.channel_busy;

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            beat_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
        end
    end

    // Next-state logic; a frame launch pops the head into the shift register
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        begin_frame = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    begin_frame = 1'b1;
                end
            end
            S_START: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                shift_d = shift_q >> LANES;
                if (beat_q == C_BEAT_LAST) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else if (start_ok) begin
                    begin_frame = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == C_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (begin_frame) begin
            state_d  = S_START;
            shift_d  = head;
            parity_d = ^head;
            beat_d   = '0;
        end
    end

    assign pop = begin_frame;

    // ------------------------------------------------------------------
    // Link outputs decoded from the registered state
    // ------------------------------------------------------------------
    logic [LANES-1:0] serial;
    logic             active;

    // Beat decode; lanes are held low whenever no frame is on the wire
    always_comb begin
        serial = '0;
        active = 1'b0;
        case (state_q)
            S_START: begin
                serial = '1;
                active = 1'b1;
            end
            S_DATA: begin
                serial = shift_q[LANES-1:0];
                active = 1'b1;
            end
            S_PARITY: begin
                serial[0] = parity_q;
                active    = 1'b1;
            end
            S_STOP: begin
                serial = '1;
                active = 1'b1;
            end
            default: begin
                serial = '0;
                active = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.serial_out = serial;
    assign bus.tx_active  = active;
    assign bus.tx_busy    = active | bus.channel_busy;
    assign bus.fifo_count = count_q;
    assign bus.drop_pulse = bus.in_valid & ~in_ready;

endmodule
`default_nettype wire

// File: tb/tb_flit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flit_serializer
//  Description : Directed self-checking bench for flit_serializer using three
//                configurations (16b/1 lane, 8b/2 lanes with parity,
//                8b/1 lane with GAP=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flit_serializer;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    flit_serializer_if #(.FLIT_W(16), .LANES(1), .FIFO_DEPTH(2)) ia ();
    flit_serializer_if #(.FLIT_W(8),  .LANES(2), .FIFO_DEPTH(2)) ib ();
    flit_serializer_if #(.FLIT_W(8),  .LANES(1), .FIFO_DEPTH(2)) ic ();

    flit_serializer #(.FLIT_W(16), .LANES(1), .FIFO_DEPTH(2), .PARITY_EN(0), .GAP(1))
        u_a (.clk(clk), .reset(reset), .bus(ia));
    flit_serializer #(.FLIT_W(8), .LANES(2), .FIFO_DEPTH(2), .PARITY_EN(1), .GAP(1))
        u_b (.clk(clk), .reset(reset), .bus(ib));
    flit_serializer #(.FLIT_W(8), .LANES(1), .FIFO_DEPTH(2), .PARITY_EN(0), .GAP(0))
        u_c (.clk(clk), .reset(reset), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int exp_a [18] = '{1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,1};
        int exp_b [7]  = '{3,0,1,3,2,0,3};
        logic [29:0] exp_c;
        logic [29:0] obs;
        logic        act_all;
        logic [15:0] data;
        int          n;
        int          guard;

        n_total = 0;
        n_bad   = 0;
        exp_c   = 30'b1100010001_1010001001_1110011001;
        ia.in_valid = 1'b0; ia.in_flit = '0; ia.channel_busy = 1'b0;
        ib.in_valid = 1'b0; ib.in_flit = '0; ib.channel_busy = 1'b0;
        ic.in_valid = 1'b0; ic.in_flit = '0; ic.channel_busy = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_serial", 32'(ia.serial_out), 0);
        check_eq("rst_active", 32'(ia.tx_active), 0);
        check_eq("rst_count",  32'(ia.fifo_count), 0);
        check_eq("rst_drop",   32'(ia.drop_pulse), 0);
        check_eq("rst_ready",  32'(ia.in_ready), 1);
        check_eq("rst_ready_b", 32'(ib.in_ready), 1);

        // Single frame 0xA5C3 on 16-bit / 1-lane
        ia.in_valid = 1'b1;
        ia.in_flit  = 16'hA5C3;
        tick();
        ia.in_valid = 1'b0;
        check_eq("a_count_queued", 32'(ia.fifo_count), 1);
        check_eq("a_idle_before_pop", 32'(ia.tx_active), 0);
        tick();
        for (int i = 0; i < 18; i++) begin
            check_eq($sformatf("a_beat%0d", i), 32'(ia.serial_out), 32'(exp_a[i]));
            check_eq($sformatf("a_active%0d", i), 32'(ia.tx_active), 1);
            tick();
        end
        check_eq("a_gap_active", 32'(ia.tx_active), 0);
        check_eq("a_gap_serial", 32'(ia.serial_out), 0);
        tick();
        tick();

        // 8-bit / 2 lanes / parity, flit 0xB4
        ib.in_valid = 1'b1;
        ib.in_flit  = 8'hB4;
        tick();
        ib.in_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("b_beat%0d", i), 32'(ib.serial_out), 32'(exp_b[i]));
            check_eq($sformatf("b_active%0d", i), 32'(ib.tx_active), 1);
            tick();
        end
        check_eq("b_after_active", 32'(ib.tx_active), 0);
        tick();
        tick();

        // channel_busy holds off the frame start
        ia.channel_busy = 1'b1;
        ia.in_valid     = 1'b1;
        ia.in_flit      = 16'h1234;
        tick();
        ia.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("busy_no_start", 32'(ia.tx_active), 0);
            check_eq("busy_count", 32'(ia.fifo_count), 1);
            check_eq("busy_tx_busy", 32'(ia.tx_busy), 1);
            tick();
        end
        ia.channel_busy = 1'b0;
        #1;
        check_eq("release_tx_busy", 32'(ia.tx_busy), 0);
        tick();
        check_eq("release_start_active", 32'(ia.tx_active), 1);
        check_eq("release_start_serial", 32'(ia.serial_out), 1);
        ia.channel_busy = 1'b1;
        n = 1;
        guard = 0;
        tick();
        while (ia.tx_active && guard < 40) begin
            n++;
            guard++;
            tick();
        end
        check_eq("busy_midframe_len", 32'(n), 18);
        ia.channel_busy = 1'b0;
        tick();
        tick();

        // GAP=0: three consecutive pushes, back-to-back frames, full refusal
        ic.in_valid = 1'b1;
        ic.in_flit  = 8'h11;
        check_eq("c_ready0", 32'(ic.in_ready), 1);
        tick();
        ic.in_flit = 8'h22;
        check_eq("c_ready1", 32'(ic.in_ready), 1);
        check_eq("c_count1", 32'(ic.fifo_count), 1);
        tick();
        check_eq("c_third_ready", 32'(ic.in_ready), 1);
        check_eq("c_third_count", 32'(ic.fifo_count), 1);
        ic.in_flit = 8'h33;
        obs     = '0;
        act_all = 1'b1;
        for (int i = 0; i < 30; i++) begin
            obs     = {obs[28:0], ic.serial_out[0]};
            act_all = act_all & ic.tx_active;
            if (i == 1) begin
                ic.in_valid = 1'b0;
                check_eq("c_full_count", 32'(ic.fifo_count), 2);
                check_eq("c_full_ready", 32'(ic.in_ready), 0);
            end
            if (i == 9) begin
                check_eq("c_stop_count", 32'(ic.fifo_count), 2);
                ic.in_valid = 1'b1;
                ic.in_flit  = 8'hFF;
                #1;
                check_eq("c_nobypass_ready", 32'(ic.in_ready), 0);
                check_eq("c_nobypass_drop", 32'(ic.drop_pulse), 1);
            end
            if (i == 10) begin
                ic.in_valid = 1'b0;
                check_eq("c_after_pop_count", 32'(ic.fifo_count), 1);
            end
            tick();
        end
        check_eq("c_trace", 32'(obs), 32'(exp_c));
        check_eq("c_all_active", 32'(act_all), 1);
        check_eq("c_end_active", 32'(ic.tx_active), 0);
        check_eq("c_end_count", 32'(ic.fifo_count), 0);
        tick();

        // Drop when full: flit discarded and never transmitted
        ia.channel_busy = 1'b1;
        ia.in_valid     = 1'b1;
        ia.in_flit      = 16'h0F0F;
        tick();
        ia.in_flit = 16'h00F0;
        tick();
        check_eq("drop_ready_low", 32'(ia.in_ready), 0);
        ia.in_flit = 16'hFFFF;
        #1;
        check_eq("drop_pulse_high", 32'(ia.drop_pulse), 1);
        tick();
        ia.in_valid = 1'b0;
        #1;
        check_eq("drop_pulse_low", 32'(ia.drop_pulse), 0);
        check_eq("drop_count_kept", 32'(ia.fifo_count), 2);
        ia.channel_busy = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ia.tx_active) n++;
        end
        check_eq("drop_active_cycles", 32'(n), 36);
        check_eq("drop_end_count", 32'(ia.fifo_count), 0);

        // Reset during DATA beat 5 aborts and flushes
        ia.in_valid = 1'b1;
        ia.in_flit  = 16'h5555;
        tick();
        ia.in_flit = 16'h3333;
        tick();
        ia.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("mid_active", 32'(ia.tx_active), 1);
        check_eq("mid_count", 32'(ia.fifo_count), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_serial", 32'(ia.serial_out), 0);
        check_eq("abort_active", 32'(ia.tx_active), 0);
        check_eq("abort_count", 32'(ia.fifo_count), 0);
        ia.in_valid = 1'b1;
        ia.in_flit  = 16'h00A5;
        tick();
        ia.in_valid = 1'b0;
        tick();
        check_eq("post_start", 32'(ia.serial_out), 1);
        check_eq("post_start_active", 32'(ia.tx_active), 1);
        data = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            data[i] = ia.serial_out[0];
        end
        tick();
        check_eq("post_stop", 32'(ia.serial_out), 1);
        check_eq("post_data", 32'(data), 32'h00A5);
        tick();
        check_eq("post_gap_active", 32'(ia.tx_active), 0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("post_no_flushed_frame", 32'(ia.tx_active), 0);
        check_eq("post_count", 32'(ia.fifo_count), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
